// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback, issue and scoreboard-query signals shared between the requesters,
// decode and the writeback arbiter. The register-file write port is included.
interface regfile_writeback_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      i_AluValid;
    logic [REG_ADDR_WIDTH-1:0] i_AluRd;
    logic [DATA_WIDTH-1:0]     i_AluData;
    logic                      o_AluReady;

    logic                      i_LoadValid;
    logic [REG_ADDR_WIDTH-1:0] i_LoadRd;
    logic [DATA_WIDTH-1:0]     i_LoadData;
    logic                      o_LoadReady;

    logic                      i_IssueValid;
    logic [REG_ADDR_WIDTH-1:0] i_IssueRd;
    logic [REG_ADDR_WIDTH-1:0] i_CheckRs1;
    logic [REG_ADDR_WIDTH-1:0] i_CheckRs2;
    logic                      o_Rs1Busy;
    logic                      o_Rs2Busy;
    logic                      i_Flush;

    logic                      o_WriteEnable;
    logic [REG_ADDR_WIDTH-1:0] o_RegDest;
    logic [DATA_WIDTH-1:0]     o_DataIn;

    // Arbiter side.
    modport slave (
        input  i_AluValid, i_AluRd, i_AluData,
        output o_AluReady,
        input  i_LoadValid, i_LoadRd, i_LoadData,
        output o_LoadReady,
        input  i_IssueValid, i_IssueRd, i_CheckRs1, i_CheckRs2, i_Flush,
        output o_Rs1Busy, o_Rs2Busy,
        output o_WriteEnable, o_RegDest, o_DataIn
    );

    // Requester / decode / register-file side.
    modport master (
        output i_AluValid, i_AluRd, i_AluData,
        input  o_AluReady,
        output i_LoadValid, i_LoadRd, i_LoadData,
        input  o_LoadReady,
        output i_IssueValid, i_IssueRd, i_CheckRs1, i_CheckRs2, i_Flush,
        input  o_Rs1Busy, o_Rs2Busy,
        input  o_WriteEnable, o_RegDest, o_DataIn
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Round-robin arbiter between ALU and load writeback onto the single register-file
// write port, plus the busy-register scoreboard decode uses to stall.
module regfile_writeback_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset_n,
    regfile_writeback_arbiter_if.slave  bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_e;

    req_e                      last_grant_q, last_grant_d;
    logic [NUM_REGS-1:0]       busy_q, busy_d;
    logic                      write_en_q, write_en_d;
    logic [REG_ADDR_WIDTH-1:0] reg_dest_q, reg_dest_d;
    logic [DATA_WIDTH-1:0]     data_in_q, data_in_d;

    logic                      alu_grant;
    logic                      load_grant;
    logic [REG_ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0]     grant_data;

    // On contention the requester that did not win last time goes next.
    assign alu_grant  = bus.i_AluValid  && (!bus.i_LoadValid || last_grant_q == REQ_LOAD);
    assign load_grant = bus.i_LoadValid && (!bus.i_AluValid  || last_grant_q == REQ_ALU);

    assign bus.o_AluReady  = alu_grant;
    assign bus.o_LoadReady = load_grant;

    assign grant_rd   = load_grant ? bus.i_LoadRd   : bus.i_AluRd;
    assign grant_data = load_grant ? bus.i_LoadData : bus.i_AluData;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        last_grant_d = last_grant_q;
        write_en_d   = 1'b0;
        reg_dest_d   = reg_dest_q;
        data_in_d    = data_in_q;
        busy_d       = busy_q;

        if (alu_grant || load_grant) begin
            last_grant_d       = load_grant ? REQ_LOAD : REQ_ALU;
            write_en_d         = (grant_rd != '0);
            reg_dest_d         = grant_rd;
            data_in_d          = grant_data;
            busy_d[grant_rd]   = 1'b0;
        end

        // Issue after the clear so a new producer of the same register stays outstanding.
        if (bus.i_IssueValid)
            busy_d[bus.i_IssueRd] = 1'b1;

        busy_d[0] = 1'b0;

        if (bus.i_Flush)
            busy_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            last_grant_q <= REQ_LOAD;
            busy_q       <= '0;
            write_en_q   <= 1'b0;
            reg_dest_q   <= '0;
            data_in_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            write_en_q   <= write_en_d;
            reg_dest_q   <= reg_dest_d;
            data_in_q    <= data_in_d;
        end
    end

    assign bus.o_Rs1Busy     = busy_q[bus.i_CheckRs1];
    assign bus.o_Rs2Busy     = busy_q[bus.i_CheckRs2];
    assign bus.o_WriteEnable = write_en_q;
    assign bus.o_RegDest     = reg_dest_q;
    assign bus.o_DataIn      = data_in_q;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: reset, single write, round-robin
// contention, scoreboard set/clear priorities, register 0, flush and async reset.
module tb_regfile_writeback_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_writeback_arbiter_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    regfile_writeback_arbiter #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .i_Clock  (clk),
        .i_Reset_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        rst_n            = 1'b0;
        bus.i_AluValid   = 1'b1;
        bus.i_AluRd      = 5'd1;
        bus.i_AluData    = 32'h11;
        bus.i_LoadValid  = 1'b1;
        bus.i_LoadRd     = 5'd2;
        bus.i_LoadData   = 32'h22;
        bus.i_IssueValid = 1'b0;
        bus.i_IssueRd    = 5'd0;
        bus.i_CheckRs1   = 5'd7;
        bus.i_CheckRs2   = 5'd2;
        bus.i_Flush      = 1'b0;

        // Reset held across edges with both requesters pending.
        #12;
        check("rst_we",        bus.o_WriteEnable, 0);
        check("rst_dest",      bus.o_RegDest, 0);
        check("rst_data",      bus.o_DataIn, 0);
        check("rst_rs1busy",   bus.o_Rs1Busy, 0);
        check("rst_rs2busy",   bus.o_Rs2Busy, 0);
        check("rst_alu_ready", bus.o_AluReady, 1);
        check("rst_ld_ready",  bus.o_LoadReady, 0);

        // Release mid-cycle; contention alternates ALU, load, ALU, load.
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("cont_alu_ready", bus.o_AluReady,  (k % 2 == 0) ? 1 : 0);
            check("cont_ld_ready",  bus.o_LoadReady, (k % 2 == 1) ? 1 : 0);
            tick();
            check("cont_we",   bus.o_WriteEnable, 1);
            check("cont_dest", bus.o_RegDest, (k % 2 == 0) ? 1 : 2);
            check("cont_data", bus.o_DataIn,  (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        bus.i_AluValid  = 1'b0;
        bus.i_LoadValid = 1'b0;
        tick();
        check("idle_we",   bus.o_WriteEnable, 0);
        check("idle_dest", bus.o_RegDest, 2);

        // Single ALU write.
        bus.i_AluValid = 1'b1;
        bus.i_AluRd    = 5'd5;
        bus.i_AluData  = 32'hDEADBEEF;
        #1;
        check("single_ready", bus.o_AluReady, 1);
        tick();
        bus.i_AluValid = 1'b0;
        check("single_we",   bus.o_WriteEnable, 1);
        check("single_dest", bus.o_RegDest, 5);
        check("single_data", bus.o_DataIn, 32'hDEADBEEF);
        tick();
        check("single_we_off", bus.o_WriteEnable, 0);
        check("single_hold",   bus.o_DataIn, 32'hDEADBEEF);

        // Scoreboard: issue rd7, visible only the cycle after.
        bus.i_IssueValid = 1'b1;
        bus.i_IssueRd    = 5'd7;
        bus.i_CheckRs1   = 5'd7;
        #1;
        check("sb_issue_same_cycle", bus.o_Rs1Busy, 0);
        tick();
        bus.i_IssueValid = 1'b0;
        check("sb_busy_set", bus.o_Rs1Busy, 1);

        // Load writes rd7: busy clears at the grant edge.
        bus.i_LoadValid = 1'b1;
        bus.i_LoadRd    = 5'd7;
        bus.i_LoadData  = 32'h77;
        #1;
        check("sb_ld_ready", bus.o_LoadReady, 1);
        check("sb_busy_during_grant", bus.o_Rs1Busy, 1);
        tick();
        bus.i_LoadValid = 1'b0;
        check("sb_busy_cleared", bus.o_Rs1Busy, 0);
        check("sb_we",   bus.o_WriteEnable, 1);
        check("sb_dest", bus.o_RegDest, 7);

        // Re-issue rd7, then issue and grant rd7 together: set wins.
        bus.i_IssueValid = 1'b1;
        tick();
        check("sb_reissue", bus.o_Rs1Busy, 1);
        bus.i_LoadValid = 1'b1;
        tick();
        bus.i_IssueValid = 1'b0;
        bus.i_LoadValid  = 1'b0;
        check("sb_set_wins", bus.o_Rs1Busy, 1);

        // Issue rd8 while rd7 is granted: both apply.
        bus.i_IssueValid = 1'b1;
        bus.i_IssueRd    = 5'd8;
        bus.i_LoadValid  = 1'b1;
        bus.i_CheckRs2   = 5'd8;
        tick();
        bus.i_IssueValid = 1'b0;
        bus.i_LoadValid  = 1'b0;
        check("sb_diff_clear", bus.o_Rs1Busy, 0);
        check("sb_diff_set",   bus.o_Rs2Busy, 1);

        // Register 0: accepted, never written, never busy.
        bus.i_AluValid   = 1'b1;
        bus.i_AluRd      = 5'd0;
        bus.i_AluData    = 32'hFFFFFFFF;
        bus.i_IssueValid = 1'b1;
        bus.i_IssueRd    = 5'd0;
        bus.i_CheckRs1   = 5'd0;
        #1;
        check("x0_ready", bus.o_AluReady, 1);
        tick();
        bus.i_AluValid   = 1'b0;
        bus.i_IssueValid = 1'b0;
        check("x0_we",   bus.o_WriteEnable, 0);
        check("x0_busy", bus.o_Rs1Busy, 0);

        // Pointer moved to ALU on the x0 grant, so load wins the next contention.
        bus.i_AluValid  = 1'b1;
        bus.i_AluRd     = 5'd10;
        bus.i_LoadValid = 1'b1;
        bus.i_LoadRd    = 5'd11;
        bus.i_LoadData  = 32'hB0B;
        #1;
        check("x0_ptr_alu_ready", bus.o_AluReady, 0);
        check("x0_ptr_ld_ready",  bus.o_LoadReady, 1);
        tick();
        bus.i_AluValid  = 1'b0;
        bus.i_LoadValid = 1'b0;
        check("x0_ptr_dest", bus.o_RegDest, 11);

        // Flush: issue rd3 and rd9, then flush with a same-cycle issue and grant.
        bus.i_IssueValid = 1'b1;
        bus.i_IssueRd    = 5'd3;
        tick();
        bus.i_IssueRd    = 5'd9;
        tick();
        bus.i_IssueValid = 1'b0;
        bus.i_CheckRs1   = 5'd3;
        bus.i_CheckRs2   = 5'd9;
        #1;
        check("fl_busy3", bus.o_Rs1Busy, 1);
        check("fl_busy9", bus.o_Rs2Busy, 1);
        bus.i_Flush      = 1'b1;
        bus.i_IssueValid = 1'b1;
        bus.i_IssueRd    = 5'd3;
        bus.i_AluValid   = 1'b1;
        bus.i_AluRd      = 5'd12;
        bus.i_AluData    = 32'hC0FFEE;
        tick();
        bus.i_Flush      = 1'b0;
        bus.i_IssueValid = 1'b0;
        bus.i_AluValid   = 1'b0;
        check("fl_clear3", bus.o_Rs1Busy, 0);
        check("fl_clear9", bus.o_Rs2Busy, 0);
        check("fl_we",     bus.o_WriteEnable, 1);
        check("fl_dest",   bus.o_RegDest, 12);

        // Async reset between edges of a granted write.
        bus.i_IssueValid = 1'b1;
        bus.i_IssueRd    = 5'd14;
        bus.i_CheckRs1   = 5'd14;
        tick();
        bus.i_IssueValid = 1'b0;
        bus.i_AluValid   = 1'b1;
        bus.i_AluRd      = 5'd13;
        bus.i_AluData    = 32'hAB;
        tick();
        check("ar_we_before", bus.o_WriteEnable, 1);
        check("ar_busy_before", bus.o_Rs1Busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_we",   bus.o_WriteEnable, 0);
        check("ar_dest", bus.o_RegDest, 0);
        check("ar_data", bus.o_DataIn, 0);
        check("ar_busy", bus.o_Rs1Busy, 0);
        bus.i_AluValid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        check("ar_idle_we", bus.o_WriteEnable, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
